// File: rtl/token_pkg.sv
// Shared field widths and the token record layout used by the token queue
// and its users.
package token_pkg;

    localparam int DATA_W_D = 144;
    localparam int POS_W_D  = 16;
    localparam int ADDR_W_D = 17;
    localparam int GARB_W_D = 2;

    typedef struct packed {
        logic [DATA_W_D-1:0] data;
        logic [POS_W_D-1:0]  position;
        logic [ADDR_W_D-1:0] address;
        logic [GARB_W_D-1:0] garbage;
        logic                lit_flag;
    } token_rec_t;

    localparam int REC_W_D = $bits(token_rec_t);

endpackage

// File: rtl/token_ram.sv
// Simple dual-port RAM with a registered, resettable read port; the read
// register doubles as the queue's head register.
module token_ram #(
    parameter int W     = 180,
    parameter int DEPTH = 64,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [W-1:0]  wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [W-1:0]  rd_data
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)        rd_data <= '0;
        else if (clr)   rd_data <= '0;
        else if (rd_en) rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/token_queue_fwft.sv
// First-word-fall-through token queue: RAM-backed storage with a registered
// head record, occupancy count, almost-full threshold, flush and sticky errors.
module token_queue_fwft
    import token_pkg::*;
#(
    parameter int DATA_W       = DATA_W_D,
    parameter int POS_W        = POS_W_D,
    parameter int ADDR_W       = ADDR_W_D,
    parameter int GARB_W       = GARB_W_D,
    parameter int DEPTH        = 64,
    parameter int AFULL_THRESH = 48,
    localparam int CW          = $clog2(DEPTH+1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              wrreq,
    input  logic [DATA_W-1:0] data_in,
    input  logic [POS_W-1:0]  position_in,
    input  logic [ADDR_W-1:0] address_in,
    input  logic [GARB_W-1:0] garbage_in,
    input  logic              lit_flag_in,
    input  logic              rdreq,
    output logic [DATA_W-1:0] data_out,
    output logic [POS_W-1:0]  position_out,
    output logic [ADDR_W-1:0] address_out,
    output logic [GARB_W-1:0] garbage_out,
    output logic              lit_flag_out,
    output logic              valid_out,
    output logic              isempty,
    output logic              full,
    output logic              almost_full,
    output logic [CW-1:0]     count,
    output logic              overflow,
    output logic              underflow
);

    localparam int W  = DATA_W + POS_W + ADDR_W + GARB_W + 1;
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0] wptr, rptr, ram_occ;
    logic [W-1:0]  head;
    logic          wr_acc, pop, rd_issue;

    // Extra pointer MSB lets a completely full RAM be told apart from empty.
    assign ram_occ = wptr - rptr;

    assign isempty     = (count == '0);
    assign full        = (count == CW'(DEPTH));
    assign almost_full = (count >= CW'(AFULL_THRESH));

    always_comb begin
        wr_acc   = wrreq & ~full & ~flush;
        pop      = rdreq & valid_out & ~flush;
        rd_issue = ~flush & (ram_occ != '0) & (~valid_out | pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
            valid_out <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (flush) begin
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
            valid_out <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_acc)   wptr <= wptr + PW'(1);
            if (rd_issue) rptr <= rptr + PW'(1);
            if (rd_issue)  valid_out <= 1'b1;
            else if (pop)  valid_out <= 1'b0;
            count <= count + CW'(wr_acc) - CW'(pop);
            // A pop in the same cycle does not rescue a write seen while full.
            if (wrreq & full)       overflow  <= 1'b1;
            if (rdreq & ~valid_out) underflow <= 1'b1;
        end
    end

    token_ram #(.W(W), .DEPTH(DEPTH)) u_ram (
        .clk     (clk),
        .rst     (rst),
        .clr     (flush),
        .wr_en   (wr_acc),
        .wr_addr (wptr[AW-1:0]),
        .wr_data ({data_in, position_in, address_in, garbage_in, lit_flag_in}),
        .rd_en   (rd_issue),
        .rd_addr (rptr[AW-1:0]),
        .rd_data (head)
    );

    assign {data_out, position_out, address_out, garbage_out, lit_flag_out} = head;

endmodule

// File: tb/tb_token_queue_fwft.sv
// Randomized scoreboard bench for token_queue_fwft against a queue-based
// reference model with a two-cycle visibility rule for the head record.
module tb_token_queue_fwft;
    import token_pkg::*;

    localparam int DEPTH = 64;
    localparam int AFT   = 48;
    localparam int CW    = $clog2(DEPTH+1);

    logic clk = 1'b0, rst = 1'b1, flush = 1'b0, wrreq = 1'b0, rdreq = 1'b0;
    token_rec_t in_rec = '0;
    logic [DATA_W_D-1:0] data_out;
    logic [POS_W_D-1:0]  position_out;
    logic [ADDR_W_D-1:0] address_out;
    logic [GARB_W_D-1:0] garbage_out;
    logic lit_flag_out, valid_out, isempty, full, almost_full, overflow, underflow;
    logic [CW-1:0] count;
    token_rec_t head_rec;

    assign head_rec = {data_out, position_out, address_out, garbage_out, lit_flag_out};

    token_queue_fwft #(.DEPTH(DEPTH), .AFULL_THRESH(AFT)) dut (
        .clk(clk), .rst(rst), .flush(flush), .wrreq(wrreq),
        .data_in(in_rec.data), .position_in(in_rec.position),
        .address_in(in_rec.address), .garbage_in(in_rec.garbage),
        .lit_flag_in(in_rec.lit_flag), .rdreq(rdreq),
        .data_out(data_out), .position_out(position_out),
        .address_out(address_out), .garbage_out(garbage_out),
        .lit_flag_out(lit_flag_out), .valid_out(valid_out),
        .isempty(isempty), .full(full), .almost_full(almost_full),
        .count(count), .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    int tests = 0, fails = 0;
    task automatic chk(input string n, input logic [191:0] got, input logic [191:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", n, got, exp);
        end
    endtask

    // Reference model: every accepted record in order, stamped with the cycle
    // it was written; a record can be at the head two cycles after its write.
    typedef struct {
        token_rec_t rec;
        int         stamp;
    } ent_t;
    ent_t q[$];
    int   cyc = 0;
    bit   m_ovf = 0, m_unf = 0, m_v, m_full;

    function automatic bit m_valid();
        return (q.size() > 0) && (q[0].stamp + 2 <= cyc);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            m_ovf = 0;
            m_unf = 0;
        end else begin
            if (flush) begin
                q.delete();
                m_ovf = 0;
                m_unf = 0;
            end else begin
                m_v    = m_valid();
                m_full = (q.size() == DEPTH);
                if (wrreq && m_full) m_ovf = 1;
                if (rdreq && !m_v)   m_unf = 1;
                if (rdreq && m_v)    void'(q.pop_front());
                if (wrreq && !m_full) q.push_back('{in_rec, cyc});
            end
            cyc++;
        end
    end

    // Monitor: compare every visible output against the model mid-cycle.
    always @(negedge clk) begin
        chk("valid_out", 192'(valid_out), 192'(m_valid()));
        chk("count", 192'(count), 192'(q.size()));
        chk("isempty", 192'(isempty), 192'(q.size() == 0));
        chk("full", 192'(full), 192'(q.size() == DEPTH));
        chk("almost_full", 192'(almost_full), 192'(q.size() >= AFT));
        chk("overflow", 192'(overflow), 192'(m_ovf));
        chk("underflow", 192'(underflow), 192'(m_unf));
        if (valid_out && m_valid())
            chk("head_rec", 192'(head_rec), 192'(q[0].rec));
    end

    int pos_ctr = 0;
    function automatic token_rec_t rand_rec(input int pos);
        token_rec_t r;
        r.data     = {$urandom, $urandom, $urandom, $urandom, $urandom};
        r.position = POS_W_D'(pos);
        r.address  = ADDR_W_D'($urandom);
        r.garbage  = GARB_W_D'($urandom);
        r.lit_flag = 1'($urandom);
        return r;
    endfunction

    task automatic cyc_rec(input bit w, input bit r, input bit f, input token_rec_t rec);
        wrreq = w; rdreq = r; flush = f; in_rec = rec;
        @(posedge clk); #1;
    endtask

    task automatic step(input bit w, input bit r, input bit f);
        token_rec_t rec;
        rec = rand_rec(pos_ctr);
        if (w) pos_ctr++;
        cyc_rec(w, r, f, rec);
    endtask

    initial begin
        token_rec_t a5;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Single write: visible two cycles later with exact fields.
        a5.data = {18{8'hA5}}; a5.position = 16'h0012; a5.address = 17'h1_0003;
        a5.garbage = 2'd2; a5.lit_flag = 1'b1;
        cyc_rec(1, 0, 0, a5);
        chk("lat_valid_t1", 192'(valid_out), 192'(0));
        step(0, 0, 0);
        chk("lat_valid_t2", 192'(valid_out), 192'(1));
        chk("lat_rec", 192'(head_rec), 192'(a5));
        chk("lat_count", 192'(count), 192'(1));
        chk("lat_isempty", 192'(isempty), 192'(0));
        step(0, 0, 1);

        // Fill to full, then write + pop while full: write dropped.
        repeat (64) step(1, 0, 0);
        step(0, 0, 0);
        chk("fill_full", 192'(full), 192'(1));
        step(1, 1, 0);
        chk("ovf_flag", 192'(overflow), 192'(1));
        chk("ovf_count", 192'(count), 192'(63));
        step(0, 0, 1);

        // Streaming write+pop; model checks ordering and constant count.
        repeat (200) step(1, 1, 0);
        chk("stream_count", 192'((count == 1) || (count == 2)), 192'(1));
        step(0, 0, 1);

        // Underflow on empty, cleared by flush.
        step(0, 1, 0);
        chk("unf_flag", 192'(underflow), 192'(1));
        chk("unf_count", 192'(count), 192'(0));
        step(0, 0, 1);
        chk("unf_flush", 192'(underflow), 192'(0));

        // Flush wins over a simultaneous write and read.
        repeat (10) step(1, 0, 0);
        step(1, 1, 1);
        chk("flush_count", 192'(count), 192'(0));
        chk("flush_valid", 192'(valid_out), 192'(0));
        chk("flush_empty", 192'(isempty), 192'(1));
        chk("flush_head", 192'(head_rec), 192'(0));

        // Random traffic with occasional flushes.
        repeat (300) step($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 50,
                          $urandom_range(0, 99) < 2);

        // Asynchronous reset mid-stream with 37 records held.
        step(0, 0, 1);
        repeat (37) step(1, 0, 0);
        chk("pre_rst_count", 192'(count), 192'(37));
        wrreq = 1'b1;
        #3 rst = 1'b1;
        #1;
        chk("rst_valid", 192'(valid_out), 192'(0));
        chk("rst_count", 192'(count), 192'(0));
        chk("rst_empty", 192'(isempty), 192'(1));
        chk("rst_head", 192'(head_rec), 192'(0));
        wrreq = 1'b0;
        @(posedge clk); #1 rst = 1'b0;

        // Refill past pointer wrap, then drain.
        repeat (150) step($urandom_range(0, 99) < 90, $urandom_range(0, 99) < 60, 0);
        repeat (80) step(0, 1, 0);
        chk("drain_empty", 192'(isempty), 192'(1));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
